hwpe_ctrl_job_sched: RTL and testbench

Next-generation HWPE control front end. It replaces the fixed acquire/trigger handshake with a parametric job queue.
- Owner-locked acquire, with a lock timeout.
- Monotonic 8-bit job IDs.
- Circular queue of N_CONTEXT pending jobs.
- Dispatcher FSM that issues start to the datapath and routes done/events to the core that offloaded each job.
- Sits between the peripheral interconnect and the engine's controller/register file.

---
 rtl/hwpe_ctrl_package.sv | 26 ++
 rtl/hwpe_ctrl_job_fifo.sv | 64 ++++++
 rtl/hwpe_ctrl_job_sched.sv | 251 +++++++++++++++++++++++++
 tb/tb_hwpe_ctrl_job_sched.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hwpe_ctrl_package.sv
// Shared types and constants for the HWPE job scheduler: register map,
// queue entry layout and dispatcher states.
package hwpe_ctrl_package;

    // Wide enough for any realistic core count; the top truncates as needed.
    localparam int unsigned CORE_W = 8;

    localparam logic [2:0] REG_TRIGGER   = 3'd0;
    localparam logic [2:0] REG_ACQUIRE   = 3'd1;
    localparam logic [2:0] REG_FINISHED  = 3'd2;
    localparam logic [2:0] REG_STATUS    = 3'd3;
    localparam logic [2:0] REG_RUNNING   = 3'd4;
    localparam logic [2:0] REG_SOFTCLEAR = 3'd5;
    localparam logic [2:0] REG_SWEVT     = 3'd6;
    localparam logic [2:0] REG_PERF      = 3'd7;

    localparam logic [31:0] ACQUIRE_BUSY = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [7:0]        id;
        logic [CORE_W-1:0] core;
    } job_entry_t;

    typedef enum logic [1:0] {StIdle, StStarting, StRunning} disp_state_e;

endpackage

// File: rtl/hwpe_ctrl_job_fifo.sv
// Circular queue of pending jobs; head is the entry currently dispatched.
module hwpe_ctrl_job_fifo
    import hwpe_ctrl_package::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear,
    input  logic             push,
    input  job_entry_t       push_data,
    input  logic             pop,
    output job_entry_t       head,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    job_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push_ok && !pop_ok) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop_ok && !push_ok) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    assign head   = mem_q[rd_ptr_q];
    assign rd_ptr = rd_ptr_q;
    assign count  = count_q;

endmodule

// File: rtl/hwpe_ctrl_job_sched.sv
// HWPE control front end: owner-locked acquire, job queue and dispatcher.
// Define HWPE_CTRL_JOB_PERF_EN to add the per-job RUNNING cycle counter (PERF).
module hwpe_ctrl_job_sched
    import hwpe_ctrl_package::*;
#(
    parameter int unsigned N_CORES         = 8,
    parameter int unsigned N_CONTEXT       = 4,
    parameter int unsigned N_EVT           = 2,
    parameter int unsigned N_SW_EVT        = 8,
    parameter int unsigned ID_WIDTH        = 16,
    parameter int unsigned ACQUIRE_TIMEOUT = 256,
    localparam int unsigned CTX_W          = $clog2(N_CONTEXT),
    localparam int unsigned CNT_W          = CTX_W + 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    output logic                       clear_o,
    input  logic                       cfg_req_i,
    output logic                       cfg_gnt_o,
    input  logic [31:0]                cfg_add_i,
    input  logic                       cfg_wen_i,
    input  logic [3:0]                 cfg_be_i,
    input  logic [31:0]                cfg_data_i,
    input  logic [ID_WIDTH-1:0]        cfg_id_i,
    output logic [31:0]                cfg_r_data_o,
    output logic                       cfg_r_valid_o,
    output logic [ID_WIDTH-1:0]        cfg_r_id_o,
    input  logic                       done_i,
    input  logic [N_EVT-2:0]           evt_i,
    output logic                       start_o,
    output logic                       busy_o,
    output logic [7:0]                 job_id_o,
    output logic [CTX_W-1:0]           context_o,
    output logic [N_CORES*N_EVT-1:0]   evt_o,
    output logic [N_SW_EVT-1:0]        sw_evt_o
);

    disp_state_e state_q, state_d;
    logic [1:0]  clr_cnt_q;
    logic        clear_act;
    logic        locked_q, error_q, start_q, r_valid_q;
    logic [CORE_W-1:0] owner_q, req_core;
    logic [31:0] timer_q, rdata, r_data_q, perf_rd;
    logic [7:0]  job_cnt_q, finished_q;
    logic [ID_WIDTH-1:0] r_id_q;
    logic [N_CORES*N_EVT-1:0] evt_q, evt_d;
    logic [N_SW_EVT-1:0] sw_evt_q, sw_evt_d;
    logic [2:0]  off;
    logic        rd, wr, acq_ok, trig_hit, trig_ok, status_rd, timeout, pop;
    job_entry_t  head;
    logic [CTX_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_count;
    logic        fifo_full, fifo_empty;
    logic        unused_in;

    assign unused_in = ^{cfg_be_i, cfg_add_i, cfg_data_i, cfg_id_i};

    assign clear_act = (clr_cnt_q != 2'd0);
    assign off       = cfg_add_i[4:2];
    assign rd        = cfg_req_i && !clear_act && cfg_wen_i;
    assign wr        = cfg_req_i && !clear_act && !cfg_wen_i;
    assign acq_ok    = rd && (off == REG_ACQUIRE) && !locked_q && !fifo_full;
    assign trig_hit  = wr && (off == REG_TRIGGER);
    assign trig_ok   = trig_hit && locked_q && (req_core == owner_q);
    assign status_rd = rd && (off == REG_STATUS);
    assign timeout   = (ACQUIRE_TIMEOUT != 0) && locked_q && (timer_q == ACQUIRE_TIMEOUT - 1);
    assign pop       = (state_q == StRunning) && done_i && !clear_act;

    // Lowest set bit wins: scan from the top so the lowest index is written last.
    always_comb begin
        req_core = '0;
        for (int i = int'(N_CORES) - 1; i >= 0; i--) begin
            if (cfg_id_i[i]) req_core = CORE_W'(i);
        end
    end

    hwpe_ctrl_job_fifo #(
        .DEPTH (N_CONTEXT)
    ) i_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear     (clear_act),
        .push      (trig_ok),
        .push_data ('{id: job_cnt_q, core: owner_q}),
        .pop       (pop),
        .head      (head),
        .rd_ptr    (rd_ptr),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        rdata = '0;
        if (rd) begin
            case (off)
                REG_ACQUIRE:  rdata = acq_ok ? {24'h0, job_cnt_q} : ACQUIRE_BUSY;
                REG_FINISHED: rdata = {24'h0, finished_q};
                REG_STATUS:   rdata = {16'h0, 8'(fifo_count), 5'h0, error_q, locked_q,
                                       state_q != StIdle};
                REG_RUNNING:  rdata = {24'h0, job_id_o};
                REG_PERF:     rdata = perf_rd;
                default:      rdata = '0;
            endcase
        end
    end

    always_comb begin
        sw_evt_d = '0;
        if (wr && (off == REG_SWEVT)) begin
            for (int i = 0; i < int'(N_SW_EVT); i++) begin
                if (cfg_data_i[3:0] == 4'(i)) sw_evt_d[i] = 1'b1;
            end
        end
    end

    always_comb begin
        evt_d = '0;
        if ((state_q == StRunning) && !clear_act) begin
            for (int c = 0; c < int'(N_CORES); c++) begin
                if (head.core == CORE_W'(c)) begin
                    evt_d[c*N_EVT]                 = done_i;
                    evt_d[c*N_EVT+1 +: N_EVT-1]    = evt_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clr_cnt_q  <= '0;
            locked_q   <= 1'b0;
            owner_q    <= '0;
            timer_q    <= '0;
            job_cnt_q  <= '0;
            finished_q <= '0;
            error_q    <= 1'b0;
        end else begin
            if (clear_act) begin
                clr_cnt_q <= clr_cnt_q - 2'd1;
            end else if (wr && (off == REG_SOFTCLEAR)) begin
                clr_cnt_q <= 2'd3;
            end
            if (clear_act) begin
                locked_q   <= 1'b0;
                owner_q    <= '0;
                timer_q    <= '0;
                job_cnt_q  <= '0;
                finished_q <= '0;
                error_q    <= 1'b0;
            end else begin
                if (trig_ok) begin
                    locked_q  <= 1'b0;
                    job_cnt_q <= job_cnt_q + 8'd1;
                end else if (acq_ok) begin
                    locked_q <= 1'b1;
                    owner_q  <= req_core;
                    timer_q  <= '0;
                end else if (timeout) begin
                    locked_q <= 1'b0;
                end else if (locked_q) begin
                    timer_q <= timer_q + 32'd1;
                end
                if (trig_hit && !trig_ok) begin
                    error_q <= 1'b1;
                end else if (status_rd) begin
                    error_q <= 1'b0;
                end
                if (pop) finished_q <= head.id;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid_q <= 1'b0;
            r_id_q    <= '0;
            r_data_q  <= '0;
            sw_evt_q  <= '0;
            evt_q     <= '0;
            start_q   <= 1'b0;
        end else begin
            r_valid_q <= cfg_req_i;
            r_id_q    <= cfg_id_i;
            r_data_q  <= rdata;
            sw_evt_q  <= sw_evt_d;
            evt_q     <= evt_d;
            start_q   <= (state_q == StStarting) && !clear_act;
        end
    end

`ifdef HWPE_CTRL_JOB_PERF_EN
    logic [31:0] perf_cnt_q, perf_q, perf_inc;

    assign perf_inc = (perf_cnt_q == '1) ? perf_cnt_q : perf_cnt_q + 32'd1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_cnt_q <= '0;
            perf_q     <= '0;
        end else if (pop) begin
            perf_q     <= perf_inc;
            perf_cnt_q <= '0;
        end else if (state_q == StRunning) begin
            perf_cnt_q <= perf_inc;
        end else begin
            perf_cnt_q <= '0;
        end
    end

    assign perf_rd = perf_q;
`else
    assign perf_rd = '0;
`endif

    // Dispatcher FSM
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= StIdle;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clear_act) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:     if (!fifo_empty) state_d = StStarting;
                StStarting: state_d = StRunning;
                StRunning:  if (done_i) state_d = StIdle;
                default:    state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        busy_o    = (state_q != StIdle);
        start_o   = start_q;
        job_id_o  = (state_q != StIdle) ? head.id : 8'h0;
        context_o = (state_q != StIdle) ? rd_ptr : '0;
    end

    assign clear_o       = clear_act;
    assign cfg_gnt_o     = 1'b1;
    assign cfg_r_valid_o = r_valid_q;
    assign cfg_r_id_o    = r_id_q;
    assign cfg_r_data_o  = r_data_q;
    assign evt_o         = evt_q;
    assign sw_evt_o      = sw_evt_q;

endmodule

// File: tb/tb_hwpe_ctrl_job_sched.sv
// Directed bench for hwpe_ctrl_job_sched; read data checked through a scoreboard queue.
module tb_hwpe_ctrl_job_sched;

    localparam int unsigned N_CORES  = 8;
    localparam int unsigned N_CTX    = 4;
    localparam int unsigned N_EVT    = 2;
    localparam int unsigned N_SW     = 8;
    localparam int unsigned IDW      = 16;
    localparam int unsigned TO       = 256;

    localparam logic [2:0] O_TRIG  = 3'd0;
    localparam logic [2:0] O_ACQ   = 3'd1;
    localparam logic [2:0] O_FIN   = 3'd2;
    localparam logic [2:0] O_STAT  = 3'd3;
    localparam logic [2:0] O_RUN   = 3'd4;
    localparam logic [2:0] O_CLR   = 3'd5;
    localparam logic [2:0] O_SWEVT = 3'd6;
    localparam logic [2:0] O_PERF  = 3'd7;

`ifdef HWPE_CTRL_JOB_PERF_EN
    localparam logic [31:0] PERF_EXP = 32'd10;
`else
    localparam logic [31:0] PERF_EXP = 32'd0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic clear;
    logic cfg_req, cfg_gnt, cfg_wen, cfg_r_valid;
    logic [31:0] cfg_add, cfg_data, cfg_r_data;
    logic [3:0] cfg_be;
    logic [IDW-1:0] cfg_id, cfg_r_id;
    logic done, start, busy;
    logic [N_EVT-2:0] evt_in;
    logic [7:0] job_id;
    logic [1:0] ctx;
    logic [N_CORES*N_EVT-1:0] evt;
    logic [N_SW-1:0] sw_evt;

    int tests_run = 0;
    int tests_failed = 0;
    logic [31:0] sb_q[$];

    always #5 clk = ~clk;

    hwpe_ctrl_job_sched #(
        .N_CORES         (N_CORES),
        .N_CONTEXT       (N_CTX),
        .N_EVT           (N_EVT),
        .N_SW_EVT        (N_SW),
        .ID_WIDTH        (IDW),
        .ACQUIRE_TIMEOUT (TO)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .clear_o       (clear),
        .cfg_req_i     (cfg_req),
        .cfg_gnt_o     (cfg_gnt),
        .cfg_add_i     (cfg_add),
        .cfg_wen_i     (cfg_wen),
        .cfg_be_i      (cfg_be),
        .cfg_data_i    (cfg_data),
        .cfg_id_i      (cfg_id),
        .cfg_r_data_o  (cfg_r_data),
        .cfg_r_valid_o (cfg_r_valid),
        .cfg_r_id_o    (cfg_r_id),
        .done_i        (done),
        .evt_i         (evt_in),
        .start_o       (start),
        .busy_o        (busy),
        .job_id_o      (job_id),
        .context_o     (ctx),
        .evt_o         (evt),
        .sw_evt_o      (sw_evt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One bus access; expected read data goes through the scoreboard.
    task automatic access(input logic wen, input logic [2:0] off, input logic [31:0] data,
                          input int core, input logic [31:0] exp, input string tag);
        logic [31:0] e;
        cfg_req  = 1'b1;
        cfg_wen  = wen;
        cfg_add  = {27'h0, off, 2'b00};
        cfg_data = data;
        cfg_id   = 16'(1) << core;
        sb_q.push_back(exp);
        tick();
        cfg_req  = 1'b0;
        cfg_wen  = 1'b0;
        cfg_add  = '0;
        cfg_data = '0;
        cfg_id   = '0;
        check({tag, "_rvalid"}, 32'(cfg_r_valid), 32'd1);
        check({tag, "_rid"}, 32'(cfg_r_id), 32'(16'(1) << core));
        e = sb_q.pop_front();
        check({tag, "_rdata"}, cfg_r_data, e);
    endtask

    task automatic rd(input logic [2:0] off, input int core, input logic [31:0] exp,
                      input string tag);
        access(1'b1, off, 32'h0, core, exp, tag);
    endtask

    task automatic wrt(input logic [2:0] off, input logic [31:0] data, input int core,
                       input string tag);
        access(1'b0, off, data, core, 32'h0, tag);
    endtask

    task automatic wait_start(input logic [7:0] exp_id, input string tag);
        int n = 0;
        while (start !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_start"}, 32'(start), 32'd1);
        check({tag, "_jobid"}, 32'(job_id), 32'(exp_id));
    endtask

    task automatic done_now(input int core, input string tag);
        done = 1'b1;
        tick();
        done = 1'b0;
        check({tag, "_doneevt"}, 32'(evt), 32'(16'(1) << (core * 2)));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; cfg_req = 1'b0; cfg_wen = 1'b0; cfg_add = '0; cfg_be = 4'hF;
        cfg_data = '0; cfg_id = '0; done = 1'b0; evt_in = '0;
        repeat (3) tick();
        check("rst_clear", 32'(clear), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_start", 32'(start), 32'd0);
        check("rst_jobid", 32'(job_id), 32'd0);
        check("rst_evt", 32'(evt), 32'd0);
        check("rst_rvalid", 32'(cfg_r_valid), 32'd0);
        check("rst_gnt", 32'(cfg_gnt), 32'd1);
        rst_n = 1'b1;
        tick();

        // First job by core 2, with an engine event while running
        rd(O_ACQ, 2, 32'd0, "acq0");
        rd(O_STAT, 0, 32'h2, "stat_locked");
        wrt(O_TRIG, 32'h0, 2, "trig0");
        check("t0_busy_idle", 32'(busy), 32'd0);
        tick();
        check("t0_busy_starting", 32'(busy), 32'd1);
        check("t0_nostart", 32'(start), 32'd0);
        tick();
        check("t0_start", 32'(start), 32'd1);
        check("t0_jobid", 32'(job_id), 32'd0);
        check("t0_ctx", 32'(ctx), 32'd0);
        evt_in = 1'b1;
        tick();
        evt_in = 1'b0;
        check("t0_start_once", 32'(start), 32'd0);
        check("t0_evt_route", 32'(evt), 32'h20);
        done_now(2, "t0");
        check("t0_idle", 32'(busy), 32'd0);
        tick();
        check("t0_evt_pulse", 32'(evt), 32'd0);
        rd(O_FIN, 0, 32'd0, "fin0");

        // Foreign trigger sets sticky error, lock stays with core 1
        rd(O_ACQ, 1, 32'd1, "acq1");
        wrt(O_TRIG, 32'h0, 3, "trig_foreign");
        rd(O_STAT, 0, 32'h6, "stat_err");
        rd(O_STAT, 0, 32'h2, "stat_errclr");
        wrt(O_TRIG, 32'h0, 1, "trig1");
        wait_start(8'd1, "j1");
        done_now(1, "j1");
        rd(O_FIN, 0, 32'd1, "fin1");

        // Fill the queue
        for (int k = 0; k < 4; k++) begin
            rd(O_ACQ, k, 32'(2 + k), "acq_fill");
            wrt(O_TRIG, 32'h0, k, "trig_fill");
        end
        rd(O_ACQ, 7, 32'hFFFF_FFFF, "acq_full");
        rd(O_STAT, 0, 32'h0401, "stat_full");
        done_now(0, "j2");
        rd(O_ACQ, 4, 32'd6, "acq6");
        rd(O_STAT, 0, 32'h0303, "stat_after_pop");

        // Lock timeout: still held at the last cycle, gone one cycle later
        repeat (254) tick();
        rd(O_STAT, 0, 32'h0303, "stat_to_edge");
        rd(O_STAT, 0, 32'h0301, "stat_to_released");
        rd(O_ACQ, 5, 32'd6, "acq6_again");
        wrt(O_TRIG, 32'h0, 5, "trig6");

        // Drain to two entries, then trigger and done in the same cycle
        done_now(1, "j3");
        wait_start(8'd4, "j4");
        done_now(2, "j4");
        wait_start(8'd5, "j5");
        check("j5_ctx", 32'(ctx), 32'd1);
        rd(O_ACQ, 6, 32'd7, "acq7");
        done = 1'b1;
        wrt(O_TRIG, 32'h0, 6, "trig7_done5");
        done = 1'b0;
        check("j5_doneevt", 32'(evt), 32'h40);
        rd(O_STAT, 0, 32'h0200, "stat_pushpop");
        rd(O_FIN, 0, 32'd5, "fin5");

        // Soft clear in the middle of job 6
        wait_start(8'd6, "j6");
        wrt(O_CLR, 32'h0, 0, "softclear");
        check("clr_c1", 32'(clear), 32'd1);
        rd(O_ACQ, 0, 32'd0, "acq_during_clr");
        check("clr_c2", 32'(clear), 32'd1);
        check("clr_busy", 32'(busy), 32'd0);
        wrt(O_SWEVT, 32'd3, 0, "swevt_during_clr");
        check("clr_c3", 32'(clear), 32'd1);
        check("clr_swevt_ignored", 32'(sw_evt), 32'd0);
        tick();
        check("clr_end", 32'(clear), 32'd0);
        rd(O_STAT, 0, 32'h0, "stat_cleared");
        rd(O_FIN, 0, 32'd0, "fin_cleared");
        rd(O_ACQ, 0, 32'd0, "acq_after_clr");

        // Software events
        wrt(O_SWEVT, 32'd3, 1, "swevt3");
        check("swevt3_pulse", 32'(sw_evt), 32'h8);
        tick();
        check("swevt3_end", 32'(sw_evt), 32'h0);
        wrt(O_SWEVT, 32'd9, 1, "swevt9");
        check("swevt9_ignored", 32'(sw_evt), 32'h0);

        // Ten-cycle job for PERF
        wrt(O_TRIG, 32'h0, 0, "trig_perf");
        wait_start(8'd0, "jp");
        check("jp_ctx", 32'(ctx), 32'd0);
        repeat (9) tick();
        done_now(0, "jp");
        rd(O_PERF, 0, PERF_EXP, "perf");
        rd(O_RUN, 0, 32'd0, "running_idle");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
